// File: rtl/adc_capture.sv
// adc_capture: ADC sample capture with format conversion, decimation, level trigger and FWFT output FIFO
module adc_capture #(
   parameter int DATA_W     = 14,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              clk_adc,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] adc_data_in,
   input  logic              adc_otr_in,
   input  logic              cfg_twos,
   input  logic [15:0]       cfg_decim,
   input  logic [15:0]       cfg_len,
   input  logic              trig_en,
   input  logic [DATA_W-1:0] trig_level,
   input  logic              arm,
   input  logic              abort,
   input  logic              clear,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic              otr_flag
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE} state_t;
   state_t state, state_nxt;
   logic [DATA_W-1:0] d1, d2, d3, lvl_q, prev_q;
   logic o1, o2, o3, k1, k2, k3;
   logic twos_q, have_prev;
   logic [15:0] decim_q, len_q, dcnt, ccnt;
   logic [DATA_W:0] mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr, rd_ptr, fill;
   logic start, fire, wr_try, is_last, full, pop, push, flush;

   function automatic logic below(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic sgn);
      return sgn ? ($signed(a) < $signed(b)) : (a < b);
   endfunction

   // Datapath qualifiers: trigger crossing, write attempt and FIFO push/pop decisions
   always_comb begin
      start   = arm && state == IDLE;
      fire    = k3 && have_prev && below(prev_q, lvl_q, twos_q) && !below(d3, lvl_q, twos_q);
      wr_try  = rst_n && !abort && k3 && (state == CAPTURE || (state == WAIT_TRIG && fire));
      is_last = len_q != 16'd0 && ccnt == len_q - 16'd1;
      fill    = wr_ptr - rd_ptr;
      full    = fill == (AW+1)'(FIFO_DEPTH);
      pop     = m_valid && m_ready;
      push    = wr_try && (!full || pop);
   end

   // State register
   always_ff @(posedge clk_adc) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   end

   // Next state; samples still in flight are dropped whenever the capture ends
   always_comb begin
      state_nxt = abort ? IDLE :
                  start ? (trig_en ? WAIT_TRIG : CAPTURE) :
                  (wr_try && is_last) ? IDLE :
                  (state == WAIT_TRIG && fire) ? CAPTURE : state;
      flush     = state_nxt == IDLE;
   end

   // Outputs; FIFO head reads as zero when empty
   always_comb begin
      busy    = state != IDLE;
      m_valid = fill != '0;
      m_data  = m_valid ? mem[rd_ptr[AW-1:0]][DATA_W-1:0] : '0;
      m_last  = m_valid && mem[rd_ptr[AW-1:0]][DATA_W];
      done    = wr_try && is_last;
   end

   // Two input register stages then conversion stage; keep tags are assigned as samples enter
   always_ff @(posedge clk_adc) begin
      if (!rst_n) begin
         {d1, d2, d3} <= '0;
         {o1, o2, o3, k1, k2, k3} <= '0;
      end else begin
         d1 <= adc_data_in;
         o1 <= adc_otr_in;
         d2 <= d1;
         o2 <= o1;
         d3 <= {d2[DATA_W-1] ^ twos_q, d2[DATA_W-2:0]};
         o3 <= o2;
         k1 <= !flush && (start || (busy && dcnt == 16'd0));
         k2 <= !flush && k1;
         k3 <= !flush && k2;
      end
   end

   // Configuration capture on arm, decimation/capture counters and trigger history
   always_ff @(posedge clk_adc) begin
      if (!rst_n) begin
         {twos_q, have_prev} <= '0;
         {decim_q, len_q, dcnt, ccnt} <= '0;
         {lvl_q, prev_q} <= '0;
      end else begin
         if (start) begin
            twos_q  <= cfg_twos;
            decim_q <= cfg_decim;
            len_q   <= cfg_len;
            lvl_q   <= trig_level;
         end
         dcnt      <= start ? (cfg_decim == 16'd0 ? 16'd0 : 16'd1) :
                      (busy && dcnt != decim_q) ? dcnt + 16'd1 : 16'd0;
         ccnt      <= start ? 16'd0 : wr_try ? ccnt + 16'd1 : ccnt;
         have_prev <= start ? 1'b0 : (state == WAIT_TRIG && k3) ? 1'b1 : have_prev;
         prev_q    <= (state == WAIT_TRIG && k3) ? d3 : prev_q;
      end
   end

   // FIFO pointers; abort empties the FIFO
   always_ff @(posedge clk_adc) begin
      if (!rst_n || abort) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= wr_ptr + (AW+1)'(push);
         rd_ptr <= rd_ptr + (AW+1)'(pop);
      end
   end

   // FIFO storage, last flag kept alongside the sample
   always_ff @(posedge clk_adc) begin
      if (push) mem[wr_ptr[AW-1:0]] <= {is_last, d3};
   end

   // Sticky flags; a new event wins over clear
   always_ff @(posedge clk_adc) begin
      if (!rst_n) begin
         overflow <= 1'b0;
         otr_flag <= 1'b0;
      end else begin
         overflow <= (wr_try && !push) || (overflow && !clear);
         otr_flag <= (wr_try && o3) || (otr_flag && !clear);
      end
   end
endmodule

// File: tb/tb_adc_capture.sv
// tb_adc_capture: table-driven and randomized checks of adc_capture against a sample-list reference model
module tb_adc_capture;
   localparam int DW = 14;
   localparam int NS = 300;

   logic clk_adc = 1'b0;
   logic rst_n, adc_otr_in, cfg_twos, trig_en, arm, abort, clear, m_ready;
   logic [DW-1:0] adc_data_in, trig_level, m_data;
   logic [15:0] cfg_decim, cfg_len;
   logic m_last, m_valid, busy, done, overflow, otr_flag;

   typedef struct {
      int src; int base; int decim; int len; int trig; int lvl; int twos; int rdy;
      int exp_n; int exp_first; int chk_lat;
   } vec_t;
   typedef struct { int last; int data; } word_t;

   vec_t vt[10];
   word_t got[$], exp_q[$];
   int samp[NS];
   int cyc = 0;
   int done_cnt, first_v, arm_cyc;
   int checks = 0;
   int passed = 0;

   adc_capture #(.DATA_W(DW), .FIFO_DEPTH(16)) dut (
      .clk_adc(clk_adc), .rst_n(rst_n), .adc_data_in(adc_data_in), .adc_otr_in(adc_otr_in),
      .cfg_twos(cfg_twos), .cfg_decim(cfg_decim), .cfg_len(cfg_len), .trig_en(trig_en),
      .trig_level(trig_level), .arm(arm), .abort(abort), .clear(clear), .m_data(m_data),
      .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .done(done),
      .overflow(overflow), .otr_flag(otr_flag)
   );

   always #5 clk_adc = ~clk_adc;
   always @(posedge clk_adc) cyc <= cyc + 1;

   always @(negedge clk_adc) begin
      if (rst_n) begin
         if (m_valid && m_ready) got.push_back('{int'(m_last), int'(m_data)});
         if (done) done_cnt++;
         if (m_valid && first_v < 0) first_v = cyc;
      end
   end

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act == req) passed++;
      else $display("FAIL %s: actual %0d, required %0d", name, act, req);
   endtask

   task automatic tick();
      @(posedge clk_adc);
      #1;
   endtask

   function automatic int conv(input int v, input int twos);
      return ((v % 16384) + (twos != 0 ? 8192 : 0)) % 16384;
   endfunction

   function automatic int sval(input int c, input int twos);
      return (twos != 0 && c >= 8192) ? c - 16384 : c;
   endfunction

   task automatic fill(input vec_t v);
      for (int k = 0; k < NS; k++)
         samp[k] = v.src == 0 ? (v.base + k) % 16384 :
                   v.src == 1 ? ((k % 2) != 0 ? 0 : 8192) : int'($urandom_range(0, 16383));
   endtask

   // Expected words: every (decim+1)-th sample from arm, converted, from the trigger point on
   task automatic model(input vec_t v, output int ok);
      int kv[$];
      int s;
      exp_q.delete();
      ok = 0;
      s = -1;
      for (int k = 0; k < NS; k++)
         if (k % (v.decim + 1) == 0) kv.push_back(conv(samp[k], v.twos));
      if (v.trig == 0) s = 0;
      else
         for (int j = 1; j < kv.size(); j++)
            if (sval(kv[j-1], v.twos) < sval(v.lvl, v.twos) && sval(v.lvl, v.twos) <= sval(kv[j], v.twos)) begin
               s = j;
               break;
            end
      if (s >= 0 && s + v.len <= kv.size()) begin
         for (int i = 0; i < v.len; i++) exp_q.push_back('{int'(i == v.len - 1), kv[s+i]});
         ok = 1;
      end
   endtask

   task automatic drive(input vec_t v, input int ncyc);
      got.delete();
      done_cnt = 0;
      first_v = -1;
      cfg_twos = v.twos[0];
      cfg_decim = 16'(v.decim);
      cfg_len = 16'(v.len);
      trig_en = v.trig[0];
      trig_level = DW'(v.lvl);
      for (int c = 0; c < ncyc; c++) begin
         adc_data_in = DW'(samp[c < NS ? c : NS-1]);
         arm = c == 0;
         m_ready = v.rdy == 0 ? 1'b1 : v.rdy == 1 ? 1'($urandom_range(0, 1)) : v.rdy == 2 ? 1'b0 : (c >= 19);
         if (c == 0) arm_cyc = cyc;
         tick();
      end
      arm = 1'b0;
   endtask

   task automatic drain(input int n);
      m_ready = 1'b1;
      repeat (n) tick();
   endtask

   task automatic cmp_words(input string tag);
      check({tag, "_count"}, got.size(), exp_q.size());
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
         check({tag, "_word"}, got[i].last * 16384 + got[i].data, exp_q[i].last * 16384 + exp_q[i].data);
   endtask

   initial begin
      vec_t v;
      int ok;
      //        src base decim len trig lvl  twos rdy exp_n first lat
      vt[0] = '{0, 0,    0,    8,  0,   0,    0,  0,  8,    0,    1};
      vt[1] = '{0, 0,    3,    6,  0,   0,    0,  0,  6,    0,    0};
      vt[2] = '{0, 0,    0,    5,  1,   50,   0,  0,  5,    50,   0};
      vt[3] = '{1, 0,    0,    2,  0,   0,    1,  0,  2,    0,    0};
      vt[4] = '{0, 8180, 0,    3,  1,   0,    1,  1,  3,    0,    0};
      vt[5] = '{0, 0,    1,    4,  0,   0,    1,  0,  4,    8192, 0};
      vt[6] = '{2, 0,    0,    5,  1,   5000, 0,  1,  -1,   0,    0};
      vt[7] = '{2, 0,    2,    7,  1,   0,    1,  1,  -1,   0,    0};
      vt[8] = '{2, 0,    1,    4,  0,   0,    1,  1,  -1,   0,    0};
      vt[9] = '{2, 0,    3,    10, 1,   12000,0,  1,  -1,   0,    0};

      rst_n = 1'b0; adc_otr_in = 1'b0; adc_data_in = '0; arm = 1'b0; abort = 1'b0; clear = 1'b0;
      m_ready = 1'b1; cfg_twos = 1'b0; cfg_decim = '0; cfg_len = '0; trig_en = 1'b0; trig_level = '0;
      done_cnt = 0; first_v = -1; arm_cyc = 0;
      repeat (3) tick();
      check("reset_flags", int'({m_valid, m_last, busy, done, overflow, otr_flag}), 0);
      check("reset_data", int'(m_data), 0);
      rst_n = 1'b1;
      tick();

      for (int r = 0; r < 10; r++) begin
         v = vt[r];
         ok = 0;
         for (int t = 0; t < 20 && ok == 0; t++) begin
            fill(v);
            model(v, ok);
         end
         if (ok == 0) begin
            checks++;
            $display("FAIL row%0d_setup: no completing stimulus found", r);
         end
         drive(v, NS);
         drain(40);
         cmp_words($sformatf("row%0d", r));
         if (v.exp_n >= 0) check("table_count", got.size(), v.exp_n);
         if (v.exp_n >= 0 && got.size() > 0) check("table_first", got[0].data, v.exp_first);
         if (v.chk_lat != 0) check("latency", first_v - arm_cyc, 4);
         check("done_pulses", done_cnt, 1);
         check("busy_end", int'(busy), 0);
         check("no_overflow", int'(overflow), 0);
      end

      v = '{0, 0, 0, 20, 0, 0, 0, 2, -1, 0, 0};
      fill(v);
      drive(v, 40);
      check("ovf_set", int'(overflow), 1);
      check("ovf_done", done_cnt, 1);
      check("ovf_busy", int'(busy), 0);
      check("ovf_valid", int'(m_valid), 1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("ovf_clear", int'(overflow), 0);
      drain(40);
      exp_q.delete();
      for (int i = 0; i < 16; i++) exp_q.push_back('{0, i});
      cmp_words("ovf");

      v = '{0, 0, 0, 18, 0, 0, 0, 3, -1, 0, 0};
      drive(v, 40);
      drain(40);
      exp_q.delete();
      for (int i = 0; i < 18; i++) exp_q.push_back('{int'(i == 17), i});
      cmp_words("full_pop");
      check("full_pop_ovf", int'(overflow), 0);
      check("full_pop_done", done_cnt, 1);

      v = '{0, 0, 0, 0, 0, 0, 0, 2, -1, 0, 0};
      adc_otr_in = 1'b1;
      drive(v, 10);
      adc_otr_in = 1'b0;
      check("abort_pre_valid", int'(m_valid), 1);
      check("abort_pre_busy", int'(busy), 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_valid", int'(m_valid), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_otr_kept", int'(otr_flag), 1);
      repeat (6) tick();
      check("abort_inflight", int'(m_valid), 0);
      check("abort_no_done", done_cnt, 0);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("otr_clear", int'(otr_flag), 0);

      v = '{0, 0, 0, 0, 0, 0, 0, 0, -1, 0, 0};
      adc_otr_in = 1'b1;
      drive(v, 10);
      check("rst_pre_otr", int'(otr_flag), 1);
      rst_n = 1'b0;
      tick();
      adc_otr_in = 1'b0;
      check("rst_mid_flags", int'({m_valid, m_last, busy, done, overflow, otr_flag}), 0);
      check("rst_mid_data", int'(m_data), 0);
      rst_n = 1'b1;
      repeat (6) tick();
      check("rst_after_flags", int'({m_valid, busy, overflow, otr_flag}), 0);
      check("rst_no_done", done_cnt, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/adc_capture.md
ADC_CAPTURE -- requirements
Module: adc_capture

Interface
REQ-001 Parameter DATA_W, default 14, ADC sample width in bits.
REQ-002 Parameter FIFO_DEPTH, default 16, output FIFO depth in words, power of two.
REQ-003 clk_adc  input  1  ADC sample clock; the block's only clock.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 adc_data_in  input  DATA_W  raw parallel ADC sample, offset binary.
REQ-006 adc_otr_in  input  1  ADC out-of-range indicator, aligned with adc_data_in.
REQ-007 cfg_twos  input  1  1: invert sample MSB (offset binary to two's complement); 0: pass through.
REQ-008 cfg_decim  input  16  keep 1 of every cfg_decim+1 samples.
REQ-009 cfg_len  input  16  samples per capture; 0 = continuous.
REQ-010 trig_en  input  1  1: wait for level crossing; 0: start on first kept sample.
REQ-011 trig_level  input  DATA_W  trigger threshold, in the converted sample domain.
REQ-012 arm  input  1  one-cycle start pulse.
REQ-013 abort  input  1  one-cycle stop-and-flush pulse.
REQ-014 clear  input  1  one-cycle clear of sticky flags.
REQ-015 m_data  output  DATA_W  converted sample from FIFO head.
REQ-016 m_last  output  1  marks final sample of a finite capture.
REQ-017 m_valid  output  1  FIFO head valid.
REQ-018 m_ready  input  1  consumer accept; a word transfers when m_valid and m_ready are both 1.
REQ-019 busy  output  1  high in WAIT_TRIG or CAPTURE.
REQ-020 done  output  1  one-cycle pulse when a finite capture completes.
REQ-021 overflow  output  1  sticky: a sample was dropped due to a full FIFO.
REQ-022 otr_flag  output  1  sticky: adc_otr_in was high on a captured sample.

Function
REQ-023 Input path: two register stages on adc_data_in/adc_otr_in, then one conversion/decimation stage; FIFO is first-word-fall-through; with FIFO empty and m_ready=1, a kept sample on adc_data_in at cycle N gives m_valid=1 with that sample at cycle N+4.
REQ-024 Decimation counter: cleared to 0 on arm; a sample is kept when counter==0; counter increments per sample and wraps to 0 after reaching cfg_decim; cfg_decim=0 keeps every sample.
REQ-025 FSM states: IDLE, WAIT_TRIG, CAPTURE; arm in IDLE -> WAIT_TRIG if trig_en=1, else CAPTURE; arm while busy is ignored.
REQ-026 Trigger evaluated on kept samples only: fires when prev_kept < trig_level <= cur_kept, signed compare if cfg_twos=1, unsigned if 0; first kept sample after arm never triggers; triggering sample is the first captured sample.
REQ-027 CAPTURE: every kept sample is a write attempt; capture counter counts write attempts, including dropped ones; the attempt numbered cfg_len carries m_last=1, pulses done the same cycle, and returns the FSM to IDLE.
REQ-028 cfg_len=0: CAPTURE runs until abort; m_last and done are never asserted.
REQ-029 FIFO write is accepted when not full, or when full with a pop in the same cycle; otherwise the sample is dropped and overflow is set.
REQ-030 abort: FSM -> IDLE and FIFO emptied on the next edge; samples in flight are discarded; done is not pulsed; sticky flags are kept.
REQ-031 clear: overflow and otr_flag -> 0; a set event in the same cycle wins.
REQ-032 m_data, m_last: stable while m_valid=1 and m_ready=0.
REQ-033 cfg_* and trig_* are sampled on arm and held internally for the whole capture.

Reset
REQ-034 rst_n=0 at a clk_adc edge: FSM=IDLE, FIFO empty, all counters 0, pipeline registers 0; m_valid, m_last, busy, done, overflow, otr_flag = 0; m_data = 0.
REQ-035 Reset mid-capture discards all state and data; no done pulse.

Verification
REQ-036 Ramp 0..99, cfg_decim=0, cfg_len=8, trig_en=0, m_ready=1 -> 8 words of consecutive samples, first valid 4 cycles after the sample enters, m_last on word 8, done pulse, busy falls.
REQ-037 cfg_twos=1, input 14'h2000 -> m_data 14'h0000; input 14'h0000 -> 14'h2000 (-8192); cfg_decim=3 on the ramp -> samples 0,4,8,...
REQ-038 trig_en=1, trig_level=50, cfg_twos=0, ramp input -> first captured word equals 50.
REQ-039 m_ready=0, cfg_len=20, FIFO_DEPTH=16 -> 16 words held, overflow=1; done still pulses; after clear, overflow=0.
REQ-040 Simultaneous cases: full FIFO with a pop and a write in the same cycle -> no drop; abort during CAPTURE -> m_valid=0 next cycle, busy=0; rst_n low mid-capture -> all outputs 0.
